downstream_cancel_processor: RTL and testbench
==============================================

Name: downstream_cancel_processor

Overview:
- Downstream-side writer for the per-client cancelled-orders memory (ramdownstream, 32 entries x 32 bits). The upstream risk path only reads this memory.
- Accepts cancel reports from the exchange side and performs a read-modify-write: new = stored cancelled + cancel amount.
- Also services per-client clear requests, and exposes busy/ack status and an event counter for debug.

Parameters:
- DATA_WIDTH, 32, width of amounts and stored totals
- ADDR_WIDTH, 5, client id / RAM address width
- CNT_WIDTH, 16, width of processed-event counter

Ports:
- clk  input  1  single clock; RAM read and write ports use it too
- reset  input  1  synchronous, active-high
- cancel_valid  input  1  cancel report present
- cancel_ready  output  1  block can accept a request this cycle
- clear_valid  input  1  request to zero one client's cancelled total
- client_id  input  ADDR_WIDTH  client targeted by cancel or clear
- amount  input  DATA_WIDTH  cancelled quantity (ignored for clear)
- downstream_address_write  output  ADDR_WIDTH  RAM write address
- data_write  output  DATA_WIDTH  RAM write data
- downstream_write_enable  output  1  RAM write strobe
- address_read  output  ADDR_WIDTH  RAM read address
- data_read  input  DATA_WIDTH  RAM read data, valid 1 cycle after address_read
- done  output  1  one-cycle pulse when a cancel or clear has committed
- saturated  output  1  sticky; set when any sum clipped
- event_count  output  CNT_WIDTH  committed operations, wraps

Behaviour:
- Reset (synchronous, active-high): state=IDLE; cancel_ready=1; downstream_write_enable=0; done=0; saturated=0; event_count=0; address/data outputs=0. Reset mid-operation abandons the operation with no RAM write.
- Handshake:
  - A request is accepted when cancel_ready=1 and (cancel_valid or clear_valid).
  - client_id and amount are captured on acceptance.
  - cancel_ready=1 only in IDLE.
- Simultaneous cancel_valid and clear_valid on the same cycle: clear wins, and the cancel is not accepted. The source holds cancel_valid and it is accepted on the next IDLE cycle.
- State machine:
  - IDLE: on accept-clear, go to WRITE with data=0. On accept-cancel, drive address_read=client_id and go to READ.
  - READ: RAM latency cycle, then go to ADD.
  - ADD: sum = data_read + latched amount, computed at DATA_WIDTH+1 bits. If the carry is set, result = all-ones and saturated is set. Go to WRITE.
  - WRITE: downstream_write_enable=1 for exactly one cycle, with address = latched id and data = result. Pulse done, increment event_count, return to IDLE.
- Latency: cancel = 4 cycles from accept to write (accept, READ, ADD, WRITE); clear = 2 cycles. Maximum throughput: one cancel per 4 cycles, one clear per 2 cycles.
- downstream_write_enable is never asserted outside WRITE.
- Back-to-back cancels to the same client see the prior write, because the write commits before the next read is issued. No forwarding is needed.
- amount=0 cancel: a full RMW is still performed, done pulses and the count increments.
- event_count wraps from 2^CNT_WIDTH-1 to 0.
- saturated clears only on reset.

Decomposition:
- Shared package downstream_pkg:
  - state enum (IDLE, READ, ADD, WRITE)
  - DATA_WIDTH/ADDR_WIDTH defaults
  - a saturating-add function (DATA_WIDTH+1 sum, clip on carry)
- No sub-module needed; the RAM (ramdownstream) is instantiated by the enclosing top, not inside this block.

Test Plan:
- Reset, then cancel id=3 amount=100 against a zeroed RAM -> write at cycle 4 of addr 3 data 100; done=1 for one cycle; event_count=1; then a second cancel id=3 amount=50 -> write data 150.
- Entry id=7 preloaded with 0xFFFFFFF0, cancel amount=0x20 -> write data 0xFFFFFFFF; saturated=1 and it stays 1 after subsequent normal cancels.
- cancel_valid and clear_valid asserted together, id=3 holding 150 -> clear commits first (addr 3 data 0 after 2 cycles); the held cancel amount=10 is then accepted -> final stored value 10.
- Assert reset during READ of a cancel -> no write strobe; outputs return to reset values; cancel_ready=1 on the next cycle.
- cancel_valid held high across 3 cycles while busy -> accepted once only; cancel_ready=0 in READ/ADD/WRITE; exactly one write.
- With CNT_WIDTH=2, commit 5 operations -> event_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/downstream_cancel_processor_pkg.sv
// rtl/downstream_cancel_processor_pkg.sv - shared types, defaults and saturating add for the cancel processor
//
// Purpose: state encoding, default widths and the clipping adder used by the
// downstream cancelled-orders read-modify-write path.
// Ports: none (package).

package downstream_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    ADD   = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Returns {carry, value}. On carry the value is pinned to all-ones so a
  // running total never wraps back to a small number.
  function automatic logic [DATA_WIDTH:0] sat_add(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[DATA_WIDTH]) begin
      s = {1'b1, {DATA_WIDTH{1'b1}}};
    end
    return s;
  endfunction

endpackage

// File: rtl/downstream_cancel_processor_if.sv
// rtl/downstream_cancel_processor_if.sv - request, RAM and status signal bundle for the cancel processor
//
// Purpose: groups the cancel/clear request handshake, the ramdownstream
// read/write ports and the debug status outputs.
// Modports:
//   slave  - the cancel processor (consumes requests, drives RAM and status)
//   master - the requesting side / enclosing top (drives requests, read data)

interface downstream_cancel_processor_if #(
  parameter int DATA_WIDTH = downstream_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = downstream_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = downstream_pkg::CNT_WIDTH
);

  logic                  cancel_valid;
  logic                  cancel_ready;
  logic                  clear_valid;
  logic [ADDR_WIDTH-1:0] client_id;
  logic [DATA_WIDTH-1:0] amount;
  logic [ADDR_WIDTH-1:0] downstream_address_write;
  logic [DATA_WIDTH-1:0] data_write;
  logic                  downstream_write_enable;
  logic [ADDR_WIDTH-1:0] address_read;
  logic [DATA_WIDTH-1:0] data_read;
  logic                  done;
  logic                  saturated;
  logic [CNT_WIDTH-1:0]  event_count;

  modport slave (
    input  cancel_valid, clear_valid, client_id, amount, data_read,
    output cancel_ready, downstream_address_write, data_write,
           downstream_write_enable, address_read, done, saturated, event_count
  );

  modport master (
    output cancel_valid, clear_valid, client_id, amount, data_read,
    input  cancel_ready, downstream_address_write, data_write,
           downstream_write_enable, address_read, done, saturated, event_count
  );

endinterface

// File: rtl/downstream_cancel_processor.sv
// rtl/downstream_cancel_processor.sv - read-modify-write writer for the per-client cancelled-orders RAM
//
// Purpose: accepts cancel reports (stored += amount, clipped at all-ones) and
// per-client clears (stored = 0), one operation at a time.
// Ports:
//   clk    - single clock, shared with the RAM ports
//   reset  - synchronous, active-high; abandons any operation without a write
//   bus    - downstream_cancel_processor_if.slave: request handshake
//            (cancel_valid/clear_valid/cancel_ready/client_id/amount), RAM
//            ports (address_read/data_read, downstream_address_write/
//            data_write/downstream_write_enable) and status (done, saturated,
//            event_count).
// The adder comes from downstream_pkg and is sized by its DATA_WIDTH, so the
// DATA_WIDTH parameter here is expected to stay at the package value.

module downstream_cancel_processor
  import downstream_pkg::*;
#(
  parameter int DATA_WIDTH = downstream_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = downstream_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = downstream_pkg::CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  downstream_cancel_processor_if.slave   bus
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] id_q, id_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] amount_q, amount_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  sat_q, sat_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      id_q     <= '0;
      raddr_q  <= '0;
      amount_q <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      raddr_q  <= raddr_d;
      amount_q <= amount_d;
      result_q <= result_d;
      sat_q    <= sat_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    raddr_d  = raddr_q;
    amount_d = amount_q;
    result_d = result_q;
    sat_d    = sat_q;
    cnt_d    = cnt_q;
    sum      = sat_add(bus.data_read, amount_q);

    unique case (state_q)
      IDLE: begin
        // Clear has priority; a simultaneous cancel is left pending and the
        // source keeps it asserted until the next IDLE cycle.
        if (bus.clear_valid) begin
          id_d     = bus.client_id;
          result_d = '0;
          state_d  = WRITE;
        end else if (bus.cancel_valid) begin
          id_d     = bus.client_id;
          amount_d = bus.amount;
          raddr_d  = bus.client_id;
          state_d  = READ;
        end
      end
      READ: begin
        // address_read is stable this cycle; data_read is valid in ADD.
        state_d = ADD;
      end
      ADD: begin
        result_d = sum[DATA_WIDTH-1:0];
        if (sum[DATA_WIDTH]) begin
          sat_d = 1'b1;
        end
        state_d = WRITE;
      end
      WRITE: begin
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cancel_ready             = (state_q == IDLE);
  assign bus.downstream_write_enable  = (state_q == WRITE);
  assign bus.done                     = (state_q == WRITE);
  assign bus.downstream_address_write = id_q;
  assign bus.data_write               = result_q;
  assign bus.address_read             = raddr_q;
  assign bus.saturated                = sat_q;
  assign bus.event_count              = cnt_q;

endmodule

// File: tb/tb_downstream_cancel_processor.sv
// tb/tb_downstream_cancel_processor.sv - randomized self-checking bench for downstream_cancel_processor

module tb_downstream_cancel_processor;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  downstream_cancel_processor_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
  downstream_cancel_processor_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(2))  bus2 ();

  downstream_cancel_processor #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Narrow-counter copy fed identical stimulus to observe the counter wrap.
  downstream_cancel_processor #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  assign bus2.cancel_valid = bus.cancel_valid;
  assign bus2.clear_valid  = bus.clear_valid;
  assign bus2.client_id    = bus.client_id;
  assign bus2.amount       = bus.amount;
  assign bus2.data_read    = bus.data_read;

  // RAM model with one-cycle registered read.
  bit   [DW-1:0] mem [32];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (bus.downstream_write_enable === 1'b1) mem[bus.downstream_address_write] <= bus.data_write;
    else if (pre_en) mem[pre_addr] <= pre_data;
    bus.data_read <= mem[bus.address_read];
  end

  int wr_count = 0;
  always @(negedge clk) if (bus.downstream_write_enable === 1'b1) wr_count++;

  // Reference model: stored totals, committed-op count, sticky clip flag.
  bit   [DW-1:0] ref_mem [32];
  int unsigned   ref_cnt;
  bit            ref_sat;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_add(input logic [DW-1:0] cur, input logic [DW-1:0] amt,
                                              output bit clip);
    longint unsigned s;
    s    = longint'(cur) + longint'(amt);
    clip = (s > 64'h0000_0000_FFFF_FFFF);
    return clip ? {DW{1'b1}} : s[DW-1:0];
  endfunction

  // Called ~1 time unit after a rising edge while the DUT is idle.
  task automatic do_op(input bit clr, input bit cxl, input logic [AW-1:0] id,
                       input logic [DW-1:0] amt, input bit hold);
    int            lat;
    int            w0;
    bit            clip;
    logic [DW-1:0] exp_data;
    clip = 1'b0;
    check("ready_idle", bus.cancel_ready, 1);
    bus.clear_valid  = clr;
    bus.cancel_valid = cxl;
    bus.client_id    = id;
    bus.amount       = amt;
    w0 = wr_count;
    if (clr) exp_data = '0;
    else     exp_data = model_add(ref_mem[id], amt, clip);
    @(posedge clk); #1;
    bus.clear_valid = 1'b0;
    if (!clr && !hold) bus.cancel_valid = 1'b0;
    lat = 2;
    while (bus.downstream_write_enable !== 1'b1 && lat < 10) begin
      check("ready_busy", bus.cancel_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, clr ? 2 : 4);
    check("we", bus.downstream_write_enable, 1);
    check("waddr", bus.downstream_address_write, id);
    check("wdata", bus.data_write, exp_data);
    check("done", bus.done, 1);
    check("ready_write", bus.cancel_ready, 0);
    ref_mem[id] = exp_data;
    if (clip) ref_sat = 1'b1;
    ref_cnt++;
    if (!clr) bus.cancel_valid = 1'b0;
    @(posedge clk); #1;
    check("done_pulse", bus.done, 0);
    check("we_off", bus.downstream_write_enable, 0);
    check("ready_back", bus.cancel_ready, 1);
    check("event_count", bus.event_count, ref_cnt % 65536);
    check("event_count_w2", bus2.event_count, ref_cnt % 4);
    check("saturated", bus.saturated, ref_sat);
    check("one_write", wr_count - w0, 1);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.cancel_ready, 1);
    check({tag, "_we"}, bus.downstream_write_enable, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_sat"}, bus.saturated, 0);
    check({tag, "_cnt"}, bus.event_count, 0);
    check({tag, "_raddr"}, bus.address_read, 0);
    check({tag, "_waddr"}, bus.downstream_address_write, 0);
    check({tag, "_wdata"}, bus.data_write, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    int r;
    logic [AW-1:0] id;
    logic [DW-1:0] amt;
    reset = 1'b1;
    bus.cancel_valid = 1'b0;
    bus.clear_valid  = 1'b0;
    bus.client_id    = '0;
    bus.amount       = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    ref_cnt = 0; ref_sat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic cancels, then accumulation on the same client; also covers the
    // narrow counter sequence 1,2,3,0,1 over the first five commits.
    do_op(0, 1, 5'd3, 32'd100, 0);
    do_op(0, 1, 5'd3, 32'd50, 0);
    check("stored3_150", mem[3], 150);

    // Saturation, and sticky afterwards.
    preload(5'd7, 32'hFFFF_FFF0);
    do_op(0, 1, 5'd7, 32'h20, 0);
    check("stored7_clip", mem[7], 32'hFFFF_FFFF);
    do_op(0, 1, 5'd2, 32'd5, 0);

    // Clear and cancel together: clear first, held cancel after.
    do_op(1, 1, 5'd3, 32'd10, 0);
    do_op(0, 1, 5'd3, 32'd10, 0);
    check("stored3_10", mem[3], 10);

    // Cancel held high while busy is accepted once.
    do_op(0, 1, 5'd9, 32'd7, 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("hold_no_extra", bus.downstream_write_enable, 0);
    check("stored9", mem[9], 7);

    // Zero-amount cancel still commits.
    do_op(0, 1, 5'd4, 32'd0, 0);

    // Reset while in READ abandons the operation.
    bus.cancel_valid = 1'b1; bus.client_id = 5'd5; bus.amount = 32'd9;
    w0 = wr_count;
    @(posedge clk); #1;
    check("rst_read_busy", bus.cancel_ready, 0);
    reset = 1'b1;
    bus.cancel_valid = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    reset = 1'b0;
    ref_cnt = 0;
    ref_sat = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midreset_nowrite", wr_count - w0, 0);
    check("midreset_ready", bus.cancel_ready, 1);

    // Randomized mix against the reference model.
    for (int i = 0; i < 150; i++) begin
      r   = $urandom_range(0, 9);
      id  = AW'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0:       amt = $urandom;
        1:       amt = 32'd0;
        default: amt = DW'($urandom_range(0, 5000));
      endcase
      if (r < 2) begin
        do_op(1, 1, id, amt, 0);
        do_op(0, 1, id, amt, 0);
      end else if (r < 4) begin
        do_op(1, 0, id, amt, 0);
      end else begin
        do_op(0, 1, id, amt, ($urandom_range(0, 3) == 0));
      end
    end
    for (int a = 0; a < 32; a++) begin
      check("final_mem", mem[a], ref_mem[a]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
